// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits, runtime parity/stop selection
// and an 8-entry baud table, with busy/tx_done handshake for frame pacing.
module uart_tx_cfg #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send_en,
  input  logic [DATA_W-1:0] data_byte,
  input  logic [2:0]        baud_set,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              uart_tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int DIV0  = CLK_FREQ / 9600;
  localparam int CNT_W = $clog2(DIV0);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Bit period minus one, so the slowest rate still fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] div_m1(input logic [2:0] sel);
    int baud;
    case (sel)
      3'd0:    baud = 9600;
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      3'd4:    baud = 115200;
      3'd5:    baud = 230400;
      3'd6:    baud = 460800;
      default: baud = 921600;
    endcase
    return CNT_W'(CLK_FREQ / baud - 1);
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_idx_q, stop_idx_d;
  logic              uart_tx_q, uart_tx_d;
  logic              busy_q, busy_d;
  logic              tx_done_q, tx_done_d;
  logic              bit_end;

  assign bit_end = (cnt_q == div_q);

  // The line is registered from the current state, so it trails the FSM by one
  // clock: that lag is the accept-to-start-bit latency.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    busy_d     = busy_q;
    tx_done_d  = 1'b0;
    uart_tx_d  = 1'b1;
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (send_en) begin
          state_d    = START;
          cnt_d      = '0;
          div_d      = div_m1(baud_set);
          idx_d      = '0;
          shift_d    = data_byte;
          par_en_d   = parity_mode[0] ^ parity_mode[1];
          par_bit_d  = parity_mode[0] ? ~^data_byte : ^data_byte;
          stop2_d    = stop2;
          stop_idx_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        uart_tx_d = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        uart_tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        uart_tx_d = par_bit_q;
        if (bit_end) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            tx_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      uart_tx_q  <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      uart_tx_q  <= uart_tx_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign uart_tx = uart_tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: directed frame table, randomized frames against a
// bit-list reference model, plus reset, busy, back-to-back and DATA_W=5 cases.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send_en;
  logic [7:0] data_byte;
  logic [2:0] baud_set;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       uart_tx, busy, tx_done;

  logic       send_en5;
  logic [4:0] data5;
  logic [2:0] baud5;
  logic [1:0] pm5;
  logic       stop25;
  logic       tx5, busy5, done5;

  int compared   = 0;
  int mismatched = 0;

  bit modelBits[$];

  typedef struct {
    logic [7:0] data;
    logic [2:0] baud;
    logic [1:0] pm;
    logic       s2;
    int         expTotal;
    int         expPar;
  } vec_t;

  vec_t vecs[5];

  localparam int BAUD_TAB[8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(50_000_000), .DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .send_en(send_en), .data_byte(data_byte),
    .baud_set(baud_set), .parity_mode(parity_mode), .stop2(stop2),
    .uart_tx(uart_tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_cfg #(.CLK_FREQ(50_000_000), .DATA_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .send_en(send_en5), .data_byte(data5),
    .baud_set(baud5), .parity_mode(pm5), .stop2(stop25),
    .uart_tx(tx5), .busy(busy5), .tx_done(done5)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int divOf(input logic [2:0] b);
    return 50_000_000 / BAUD_TAB[b];
  endfunction

  function automatic int frameLen(input int div, input logic [1:0] pm, input logic s2);
    return div * (1 + 8 + ((pm == 2'b01 || pm == 2'b10) ? 1 : 0) + (s2 ? 2 : 1));
  endfunction

  // Reference frame as a plain list of line levels, one per bit period.
  task automatic buildModel(input logic [7:0] d, input logic [1:0] pm, input logic s2);
    int ones = 0;
    modelBits.delete();
    modelBits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      modelBits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pm == 2'b10) modelBits.push_back(bit'(ones % 2));
    else if (pm == 2'b01) modelBits.push_back(bit'(1 - ones % 2));
    modelBits.push_back(1'b1);
    if (s2) modelBits.push_back(1'b1);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [2:0] b,
                               input logic [1:0] pm, input logic s2);
    data_byte   = d;
    baud_set    = b;
    parity_mode = pm;
    stop2       = s2;
    send_en     = 1'b1;
    @(posedge clk);
    #1;
    send_en = 1'b0;
  endtask

  task automatic idleCheck(input string name);
    @(posedge clk);
    #1;
    checkOutput({name, "_idle_line"}, int'(uart_tx), 1);
    checkOutput({name, "_idle_busy"}, int'(busy), 0);
    checkOutput({name, "_idle_done"}, int'(tx_done), 0);
  endtask

  // Called right after the accept edge; returns just after the tx_done edge.
  task automatic watchFrame(input string name, input logic [7:0] d, input logic [2:0] b,
                            input logic [1:0] pm, input logic s2, input int expTotal,
                            input int expPar, input bit poke, input bit chainOn,
                            input logic [7:0] cd, input logic [2:0] cb,
                            input logic [1:0] cpm, input logic cs2);
    int div, total, doneT, lineErr, busyErr, doneErr, firstBad, parSeen;
    buildModel(d, pm, s2);
    div      = divOf(b);
    total    = modelBits.size() * div;
    doneT    = -1;
    lineErr  = 0;
    busyErr  = 0;
    doneErr  = 0;
    firstBad = -1;
    parSeen  = -1;
    checkOutput({name, "_t0_line"}, int'(uart_tx), 1);
    checkOutput({name, "_t0_busy"}, int'(busy), 1);
    for (int t = 1; t <= total; t++) begin
      @(posedge clk);
      #1;
      send_en = 1'b0;
      if (uart_tx !== logic'(modelBits[(t - 1) / div])) begin
        lineErr++;
        if (firstBad < 0) firstBad = t;
      end
      if (busy !== logic'(t < total)) busyErr++;
      if (tx_done !== logic'(t == total)) doneErr++;
      if (tx_done === 1'b1 && doneT < 0) doneT = t;
      if (expPar >= 0 && t == 9 * div + div / 2) parSeen = int'(uart_tx);
      if (poke && t == 2 * div) begin
        data_byte   = 8'($urandom);
        baud_set    = 3'($urandom);
        parity_mode = 2'($urandom);
        stop2       = 1'($urandom);
        send_en     = 1'b1;
      end
      if (chainOn && t == total) begin
        data_byte   = cd;
        baud_set    = cb;
        parity_mode = cpm;
        stop2       = cs2;
        send_en     = 1'b1;
      end
    end
    checkOutput($sformatf("%s_line_bad_clocks(first t=%0d)", name, firstBad), lineErr, 0);
    checkOutput({name, "_busy_bad_clocks"}, busyErr, 0);
    checkOutput({name, "_done_bad_clocks"}, doneErr, 0);
    checkOutput({name, "_done_time"}, doneT, expTotal);
    if (expPar >= 0) checkOutput({name, "_parity_bit"}, parSeen, expPar);
  endtask

  initial begin
    logic [7:0] rd;
    logic [2:0] rb;
    logic [1:0] rpm;
    logic       rs2;
    int         errs;

    vecs[0] = '{8'h55, 3'd4, 2'b00, 1'b0, 4340, -1};
    vecs[1] = '{8'h07, 3'd4, 2'b10, 1'b0, 4774, 1};
    vecs[2] = '{8'h07, 3'd7, 2'b01, 1'b0, 594, 0};
    vecs[3] = '{8'hA3, 3'd0, 2'b00, 1'b1, 57288, -1};
    vecs[4] = '{8'h3C, 3'd7, 2'b11, 1'b0, 540, -1};

    rst_n = 1'b0;
    send_en = 1'b0; data_byte = '0; baud_set = '0; parity_mode = '0; stop2 = 1'b0;
    send_en5 = 1'b0; data5 = '0; baud5 = '0; pm5 = '0; stop25 = 1'b0;
    #12;
    checkOutput("reset_line", int'(uart_tx), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(tx_done), 0);
    checkOutput("reset_line5", int'(tx5), 1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].data, vecs[i].baud, vecs[i].pm, vecs[i].s2);
      watchFrame($sformatf("vec%0d", i), vecs[i].data, vecs[i].baud, vecs[i].pm, vecs[i].s2,
                 vecs[i].expTotal, vecs[i].expPar, 1'b0, 1'b0, 8'h00, 3'd0, 2'b00, 1'b0);
      idleCheck($sformatf("vec%0d", i));
    end

    // Request and input changes mid-frame must not disturb the frame in flight.
    applyStimulus(8'hC4, 3'd7, 2'b00, 1'b0);
    watchFrame("busy_ignore", 8'hC4, 3'd7, 2'b00, 1'b0, 540, -1, 1'b1, 1'b0,
               8'h00, 3'd0, 2'b00, 1'b0);
    idleCheck("busy_ignore");

    // Second request lands in the tx_done cycle of the first.
    applyStimulus(8'h96, 3'd7, 2'b10, 1'b0);
    watchFrame("b2b_first", 8'h96, 3'd7, 2'b10, 1'b0, 594, -1, 1'b0, 1'b1,
               8'h3B, 3'd7, 2'b01, 1'b1);
    @(posedge clk);
    #1;
    send_en = 1'b0;
    watchFrame("b2b_second", 8'h3B, 3'd7, 2'b01, 1'b1, 648, -1, 1'b0, 1'b0,
               8'h00, 3'd0, 2'b00, 1'b0);
    idleCheck("b2b_second");

    for (int i = 0; i < 6; i++) begin
      rd  = 8'($urandom);
      rb  = 3'(6 + $urandom_range(0, 1));
      rpm = 2'($urandom);
      rs2 = 1'($urandom);
      applyStimulus(rd, rb, rpm, rs2);
      watchFrame($sformatf("rand%0d_d%02h_b%0d_p%0d_s%0d", i, rd, rb, rpm, rs2), rd, rb, rpm, rs2,
                 frameLen(divOf(rb), rpm, rs2), -1, 1'b1, 1'b0, 8'h00, 3'd0, 2'b00, 1'b0);
      idleCheck($sformatf("rand%0d", i));
    end

    // Reset during a data bit aborts the frame immediately and silently.
    applyStimulus(8'h00, 3'd7, 2'b00, 1'b0);
    repeat (172) @(posedge clk);
    #1;
    checkOutput("rst_mid_pre_line", int'(uart_tx), 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_line", int'(uart_tx), 1);
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_done", int'(tx_done), 0);
    errs = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (tx_done !== 1'b0 || uart_tx !== 1'b1) errs++;
    end
    #3;
    rst_n = 1'b1;
    repeat (700) begin
      @(posedge clk);
      #1;
      if (tx_done !== 1'b0 || uart_tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    checkOutput("rst_mid_quiet_clocks", errs, 0);

    // DATA_W=5 instance: 0x1B even parity -> 0,1,1,0,1,1,0,1 at 54 clocks per bit.
    begin
      logic [7:0] exp5;
      int doneT5, par5;
      exp5 = 8'b1011_0110;
      data5 = 5'h1B; baud5 = 3'd7; pm5 = 2'b10; stop25 = 1'b0; send_en5 = 1'b1;
      @(posedge clk);
      #1;
      send_en5 = 1'b0;
      checkOutput("w5_t0_busy", int'(busy5), 1);
      errs = 0;
      doneT5 = -1;
      par5 = -1;
      for (int t = 1; t <= 432; t++) begin
        @(posedge clk);
        #1;
        if (tx5 !== exp5[(t - 1) / 54]) errs++;
        if (done5 === 1'b1 && doneT5 < 0) doneT5 = t;
        if (t == 6 * 54 + 27) par5 = int'(tx5);
      end
      checkOutput("w5_line_bad_clocks", errs, 0);
      checkOutput("w5_parity_bit", par5, 0);
      checkOutput("w5_done_time", doneT5, 432);
      @(posedge clk);
      #1;
      checkOutput("w5_idle_busy", int'(busy5), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
